hand_feature_extract: RTL and testbench
=======================================

HAND_FEATURE_EXTRACT -- requirements
Module: hand_feature_extract

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named fpga_clk and rst.
REQ-002 The block SHALL have parameter LENGTH, default 30, meaning the number of image rows.
REQ-003 The block SHALL have parameter WIDTH, default 60, meaning the number of image columns.
REQ-004 The block SHALL have parameter CW, default $clog2(LENGTH*WIDTH+1), meaning the width of the pixel count.
REQ-005 The block SHALL have port fpga_clk  in  1  system clock; all logic is on posedge.
REQ-006 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have port start  in  1  single-cycle frame start request.
REQ-008 The block SHALL have port pix_valid  in  1  upstream pixel valid.
REQ-009 The block SHALL have port pix_bit  in  1  hand-mask pixel, raster order, row-major, column fastest.
REQ-010 The block SHALL have port pix_ready  out  1  block accepts a pixel this cycle.
REQ-011 The block SHALL have port feat_valid  out  1  feature outputs valid.
REQ-012 The block SHALL have port feat_ready  in  1  downstream consumes features.
REQ-013 The block SHALL have port pix_count  out  CW  number of 1 pixels.
REQ-014 The block SHALL have ports min_row, max_row  out  $clog2(LENGTH)  bounding-box rows.
REQ-015 The block SHALL have ports min_col, max_col  out  $clog2(WIDTH)  bounding-box columns.
REQ-016 The block SHALL have ports sum_row, sum_col  out  24  sums of row and column indices of 1 pixels (centroid numerators).
REQ-017 The block SHALL have port empty  out  1  frame contained no 1 pixels.
REQ-018 The block SHALL have port busy  out  1  block is in state ACCUM or HOLD.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-020 In IDLE, start=1 SHALL move the FSM to ACCUM on the next edge and clear all accumulators and the row/column counters to 0.
REQ-021 The same IDLE-to-ACCUM transition SHALL load min_row and min_col with all-ones and max_row and max_col with 0.
REQ-022 The start input SHALL be ignored in ACCUM and HOLD.
REQ-023 pix_ready SHALL be 1 exactly when the state is ACCUM, as a registered state decode with no combinational path from pix_valid.
REQ-024 A pixel SHALL be accepted when pix_valid and pix_ready are both 1; cycles with pix_valid=0 SHALL change no state.
REQ-025 On an accepted pixel with pix_bit=1, the block SHALL increment pix_count by 1 and add the current row and column to sum_row and sum_col.
REQ-026 On an accepted pixel with pix_bit=1, the block SHALL update min_row, max_row, min_col and max_col with unsigned compares against the current row and column.
REQ-027 On every accepted pixel, the column SHALL increment and wrap from WIDTH-1 to 0 with a row increment.
REQ-028 Acceptance of the pixel at row LENGTH-1, column WIDTH-1 SHALL move the FSM to HOLD; that pixel's contribution is included.
REQ-029 feat_valid SHALL assert on the cycle after the last pixel is accepted, a latency of 1 cycle.
REQ-030 The row and column counters SHALL never exceed LENGTH-1 and WIDTH-1, and SHALL be unused once in HOLD.
REQ-031 In HOLD, feat_valid SHALL be 1 and all feature outputs SHALL be held stable until feat_ready=1.
REQ-032 HOLD with feat_ready=1 SHALL move the FSM to IDLE on the next edge, and feat_valid SHALL fall on that edge.
REQ-033 A start=1 in the same cycle as the HOLD-to-IDLE transition SHALL be ignored; start is sampled only in IDLE.
REQ-034 When pix_count=0 in HOLD, empty SHALL be 1 and min_row, max_row, min_col and max_col SHALL read 0, not the sentinel values.
REQ-035 When pix_count>0, empty SHALL be 0.
REQ-036 The sums SHALL be unsigned and 24 bits wide, which cannot overflow for LENGTH, WIDTH ≤ 64, so no saturation logic is required.
REQ-037 Feature outputs outside HOLD SHALL be don't-care to the consumer but SHALL be deterministic, showing the internal accumulators.
REQ-038 busy SHALL be 1 exactly when the state is ACCUM or HOLD.

Reset
REQ-039 rst=1 at a clock edge SHALL force state IDLE and clear pix_ready, feat_valid and busy to 0.
REQ-040 rst=1 at a clock edge SHALL clear pix_count, sum_row, sum_col, all four bounding-box outputs and both counters to 0, and set empty to 1.
REQ-041 rst SHALL have priority over start, pix_valid and feat_ready in the same cycle.
REQ-042 rst mid-ACCUM or mid-HOLD SHALL discard the partial frame, and the next frame SHALL require a new start.

Verification
REQ-043 The bench SHALL drive start, then 1800 pixels all 0 with pix_valid held high, and check feat_valid 1 cycle after the last pixel, pix_count=0, empty=1, all bounds 0 and both sums 0.
REQ-044 The bench SHALL drive a frame with a single 1 at row 7, column 12 and check pix_count=1, min_row=max_row=7, min_col=max_col=12, sum_row=7, sum_col=12 and empty=0.
REQ-045 The bench SHALL drive an all-ones frame and check pix_count=1800, bounds 0/29 and 0/59, sum_row=26100 and sum_col=53100.
REQ-046 The bench SHALL drive a frame with random pix_valid gaps plus start pulses mid-ACCUM, and check results identical to the gap-free run and that start is ignored.
REQ-047 The bench SHALL hold feat_ready=0 for 10 cycles in HOLD and check the outputs stable and feat_valid high; then pulse feat_ready and check IDLE and feat_valid=0 on the next cycle.
REQ-048 The bench SHALL assert rst after 900 pixels, check all outputs at reset values, then run a single-1 frame and check correct results with no residue from the aborted frame.

Source files
------------

// File: rtl/hand_feature_extract_if.sv
// Pixel-stream and feature-result bundle between the hand-mask source,
// the feature extractor and the feature consumer.
interface hand_feature_extract_if #(
  parameter int LENGTH = 30,
  parameter int WIDTH  = 60,
  parameter int CW     = $clog2(LENGTH*WIDTH+1)
);
  localparam int RW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic           start;
  logic           pix_valid;
  logic           pix_bit;
  logic           pix_ready;
  logic           feat_valid;
  logic           feat_ready;
  logic [CW-1:0]  pix_count;
  logic [RW-1:0]  min_row;
  logic [RW-1:0]  max_row;
  logic [CLW-1:0] min_col;
  logic [CLW-1:0] max_col;
  logic [23:0]    sum_row;
  logic [23:0]    sum_col;
  logic           empty;
  logic           busy;

  modport master (
    output start, pix_valid, pix_bit, feat_ready,
    input  pix_ready, feat_valid, pix_count, min_row, max_row,
           min_col, max_col, sum_row, sum_col, empty, busy
  );

  modport slave (
    input  start, pix_valid, pix_bit, feat_ready,
    output pix_ready, feat_valid, pix_count, min_row, max_row,
           min_col, max_col, sum_row, sum_col, empty, busy
  );
endinterface

// File: rtl/hand_feature_extract.sv
// Accumulates pixel count, bounding box and centroid numerators of a binary
// hand mask streamed in raster order, then holds the features until consumed.
module hand_feature_extract #(
  parameter int LENGTH = 30,
  parameter int WIDTH  = 60,
  parameter int CW     = $clog2(LENGTH*WIDTH+1)
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  hand_feature_extract_if.slave bus
);
  localparam int RW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [RW-1:0]  LAST_ROW = RW'(LENGTH - 1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e         state_q, state_d;
  logic [RW-1:0]  rowIdx_q, rowIdx_d;
  logic [CLW-1:0] colIdx_q, colIdx_d;
  logic [CW-1:0]  pixCount_q, pixCount_d;
  logic [RW-1:0]  minRow_q, minRow_d;
  logic [RW-1:0]  maxRow_q, maxRow_d;
  logic [CLW-1:0] minCol_q, minCol_d;
  logic [CLW-1:0] maxCol_q, maxCol_d;
  logic [23:0]    sumRow_q, sumRow_d;
  logic [23:0]    sumCol_q, sumCol_d;
  logic           accept;
  logic           lastPixel;
  logic           frameEmpty;

  assign accept    = (state_q == ACCUM) && bus.pix_valid;
  assign lastPixel = (rowIdx_q == LAST_ROW) && (colIdx_q == LAST_COL);

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rowIdx_q   <= '0;
      colIdx_q   <= '0;
      pixCount_q <= '0;
      minRow_q   <= '0;
      maxRow_q   <= '0;
      minCol_q   <= '0;
      maxCol_q   <= '0;
      sumRow_q   <= '0;
      sumCol_q   <= '0;
    end else begin
      state_q    <= state_d;
      rowIdx_q   <= rowIdx_d;
      colIdx_q   <= colIdx_d;
      pixCount_q <= pixCount_d;
      minRow_q   <= minRow_d;
      maxRow_q   <= maxRow_d;
      minCol_q   <= minCol_d;
      maxCol_q   <= maxCol_d;
      sumRow_q   <= sumRow_d;
      sumCol_q   <= sumCol_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rowIdx_d   = rowIdx_q;
    colIdx_d   = colIdx_q;
    pixCount_d = pixCount_q;
    minRow_d   = minRow_q;
    maxRow_d   = maxRow_q;
    minCol_d   = minCol_q;
    maxCol_d   = maxCol_q;
    sumRow_d   = sumRow_q;
    sumCol_d   = sumCol_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = ACCUM;
          rowIdx_d   = '0;
          colIdx_d   = '0;
          pixCount_d = '0;
          sumRow_d   = '0;
          sumCol_d   = '0;
          minRow_d   = '1;
          maxRow_d   = '0;
          minCol_d   = '1;
          maxCol_d   = '0;
        end
      end

      ACCUM: begin
        if (accept) begin
          if (bus.pix_bit) begin
            pixCount_d = pixCount_q + CW'(1);
            sumRow_d   = sumRow_q + 24'(rowIdx_q);
            sumCol_d   = sumCol_q + 24'(colIdx_q);
            if (rowIdx_q < minRow_q) minRow_d = rowIdx_q;
            if (rowIdx_q > maxRow_q) maxRow_d = rowIdx_q;
            if (colIdx_q < minCol_q) minCol_d = colIdx_q;
            if (colIdx_q > maxCol_q) maxCol_d = colIdx_q;
          end
          // The last pixel parks both counters at zero rather than stepping past the frame
          if (lastPixel) begin
            state_d  = HOLD;
            rowIdx_d = '0;
            colIdx_d = '0;
          end else if (colIdx_q == LAST_COL) begin
            colIdx_d = '0;
            rowIdx_d = rowIdx_q + RW'(1);
          end else begin
            colIdx_d = colIdx_q + CLW'(1);
          end
        end
      end

      HOLD: begin
        if (bus.feat_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // An empty frame reports zero bounds instead of the min/max sentinels
  assign frameEmpty     = (pixCount_q == '0);
  assign bus.pix_ready  = (state_q == ACCUM);
  assign bus.feat_valid = (state_q == HOLD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.pix_count  = pixCount_q;
  assign bus.sum_row    = sumRow_q;
  assign bus.sum_col    = sumCol_q;
  assign bus.empty      = frameEmpty;
  assign bus.min_row    = frameEmpty ? '0 : minRow_q;
  assign bus.max_row    = frameEmpty ? '0 : maxRow_q;
  assign bus.min_col    = frameEmpty ? '0 : minCol_q;
  assign bus.max_col    = frameEmpty ? '0 : maxCol_q;
endmodule

// File: tb/tb_hand_feature_extract.sv
// Scoreboard bench for hand_feature_extract: each frame pushes its modelled
// features when driven, and they are popped and compared when feat_valid rises.
module tb_hand_feature_extract;
  localparam int LENGTH = 30;
  localparam int WIDTH  = 60;
  localparam int NPIX   = LENGTH * WIDTH;

  typedef struct {
    int cnt;
    int minR;
    int maxR;
    int minC;
    int maxC;
    int sumR;
    int sumC;
    int empty;
  } feat_t;

  logic  fpga_clk = 1'b0;
  logic  rst      = 1'b1;
  bit    frame [NPIX];
  feat_t sb [$];
  int    testsRun    = 0;
  int    testsFailed = 0;

  hand_feature_extract_if #(.LENGTH(LENGTH), .WIDTH(WIDTH)) bus ();

  hand_feature_extract #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: all zero, 1: single one at (r,c), 2: all ones, 3: random
  task automatic buildFrame(input int mode, input int r, input int c);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        1:       frame[i] = (i == r * WIDTH + c);
        2:       frame[i] = 1'b1;
        3:       frame[i] = ($urandom_range(0, 3) == 0);
        default: frame[i] = 1'b0;
      endcase
    end
  endtask

  task automatic pushExpected();
    feat_t e;
    e = '{cnt: 0, minR: LENGTH, maxR: -1, minC: WIDTH, maxC: -1, sumR: 0, sumC: 0, empty: 1};
    for (int r = 0; r < LENGTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (frame[r * WIDTH + c]) begin
          e.cnt++;
          e.sumR += r;
          e.sumC += c;
          if (r < e.minR) e.minR = r;
          if (r > e.maxR) e.maxR = r;
          if (c < e.minC) e.minC = c;
          if (c > e.maxC) e.maxC = c;
        end
      end
    end
    if (e.cnt == 0) begin
      e.minR = 0; e.maxR = 0; e.minC = 0; e.maxC = 0;
    end else begin
      e.empty = 0;
    end
    sb.push_back(e);
  endtask

  task automatic compareFeatures(input string pre, input feat_t e);
    checkOutput({pre, ".count"},  32'(bus.pix_count), e.cnt);
    checkOutput({pre, ".minRow"}, 32'(bus.min_row),   e.minR);
    checkOutput({pre, ".maxRow"}, 32'(bus.max_row),   e.maxR);
    checkOutput({pre, ".minCol"}, 32'(bus.min_col),   e.minC);
    checkOutput({pre, ".maxCol"}, 32'(bus.max_col),   e.maxC);
    checkOutput({pre, ".sumRow"}, 32'(bus.sum_row),   e.sumR);
    checkOutput({pre, ".sumCol"}, 32'(bus.sum_col),   e.sumC);
    checkOutput({pre, ".empty"},  32'(bus.empty),     e.empty);
  endtask

  task automatic checkReset(input string pre);
    checkOutput({pre, ".pixReady"},  32'(bus.pix_ready),  0);
    checkOutput({pre, ".featValid"}, 32'(bus.feat_valid), 0);
    checkOutput({pre, ".busy"},      32'(bus.busy),       0);
    checkOutput({pre, ".count"},     32'(bus.pix_count),  0);
    checkOutput({pre, ".sumRow"},    32'(bus.sum_row),    0);
    checkOutput({pre, ".sumCol"},    32'(bus.sum_col),    0);
    checkOutput({pre, ".minRow"},    32'(bus.min_row),    0);
    checkOutput({pre, ".maxRow"},    32'(bus.max_row),    0);
    checkOutput({pre, ".minCol"},    32'(bus.min_col),    0);
    checkOutput({pre, ".maxCol"},    32'(bus.max_col),    0);
    checkOutput({pre, ".empty"},     32'(bus.empty),      1);
  endtask

  // abortAt > 0 stops after that many accepted pixels and expects no result
  task automatic applyStimulus(input bit gaps, input bit midStarts, input int abortAt);
    int  idx   = 0;
    int  guard = 0;
    bit  accepted;
    if (abortAt == 0) pushExpected();
    bus.start = 1'b1;
    @(posedge fpga_clk); #1;
    bus.start = 1'b0;
    checkOutput("startToAccum", 32'(bus.pix_ready), 1);
    while (idx < NPIX && (abortAt == 0 || idx < abortAt)) begin
      bus.pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pix_bit   = frame[idx];
      bus.start     = midStarts && ($urandom_range(0, 99) == 0);
      accepted      = bus.pix_valid && bus.pix_ready;
      @(posedge fpga_clk); #1;
      if (accepted) idx++;
      if (bus.start) checkOutput("midStartIgnored", 32'(bus.pix_ready), 32'(idx < NPIX));
      bus.start = 1'b0;
      guard++;
      if (guard > 4 * NPIX + 100) begin
        checkOutput("acceptTimeout", idx, NPIX);
        break;
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_bit   = 1'b0;
    if (abortAt == 0) checkOutput("featLatency", 32'(bus.feat_valid), 1);
  endtask

  task automatic collectResult(input string pre, input int holdCycles);
    feat_t e;
    int    waitCnt = 0;
    while (!bus.feat_valid && waitCnt < 50) begin
      @(posedge fpga_clk); #1;
      waitCnt++;
    end
    checkOutput({pre, ".featValid"}, 32'(bus.feat_valid), 1);
    if (sb.size() == 0) begin
      checkOutput({pre, ".scoreboardEmpty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    compareFeatures(pre, e);
    // Stall the consumer, with start pulses that must have no effect
    for (int i = 0; i < holdCycles; i++) begin
      bus.feat_ready = 1'b0;
      bus.start      = (i % 3 == 0);
      @(posedge fpga_clk); #1;
      bus.start = 1'b0;
      checkOutput({pre, ".holdValid"}, 32'(bus.feat_valid), 1);
      checkOutput({pre, ".holdCount"}, 32'(bus.pix_count), e.cnt);
      checkOutput({pre, ".holdSumRow"}, 32'(bus.sum_row), e.sumR);
      checkOutput({pre, ".holdSumCol"}, 32'(bus.sum_col), e.sumC);
      checkOutput({pre, ".holdMaxCol"}, 32'(bus.max_col), e.maxC);
    end
    bus.feat_ready = 1'b1;
    bus.start      = 1'b1;
    @(posedge fpga_clk); #1;
    bus.feat_ready = 1'b0;
    bus.start      = 1'b0;
    checkOutput({pre, ".releaseValid"}, 32'(bus.feat_valid), 0);
    checkOutput({pre, ".releaseBusy"},  32'(bus.busy),       0);
    @(posedge fpga_clk); #1;
    checkOutput({pre, ".startOnReleaseIgnored"}, 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_bit    = 1'b0;
    bus.feat_ready = 1'b0;
    repeat (3) @(posedge fpga_clk);
    #1;
    rst = 1'b0;
    checkReset("reset");

    buildFrame(0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    collectResult("allZero", 0);

    buildFrame(1, 7, 12);
    applyStimulus(1'b0, 1'b0, 0);
    collectResult("single", 10);

    buildFrame(2, 0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    collectResult("allOnes", 0);

    buildFrame(3, 0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    collectResult("randomNoGap", 0);
    applyStimulus(1'b1, 1'b1, 0);
    collectResult("randomGaps", 3);

    // Abort a full-ones frame halfway; reset wins over every other input
    buildFrame(2, 0, 0);
    applyStimulus(1'b0, 1'b0, 900);
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.pix_valid  = 1'b1;
    bus.pix_bit    = 1'b1;
    bus.feat_ready = 1'b1;
    @(posedge fpga_clk); #1;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.feat_ready = 1'b0;
    checkReset("abortReset");
    repeat (5) @(posedge fpga_clk);
    #1;
    checkOutput("noStartNoAccum", 32'(bus.busy), 0);
    checkOutput("noStartCount", 32'(bus.pix_count), 0);
    bus.pix_valid = 1'b0;
    bus.pix_bit   = 1'b0;

    buildFrame(1, 20, 45);
    applyStimulus(1'b0, 1'b0, 0);
    collectResult("afterAbort", 0);

    checkOutput("scoreboardDrained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
